// File: rtl/spi_flash_sequencer.sv
`default_nettype none
//============================================================================
// Module   : spi_flash_sequencer
// Purpose  : Drives an SPI byte engine through complete flash READ (0x03)
//            and DUAL OUTPUT READ (0x3B) transactions: chip select, opcode,
//            24-bit address, optional dummy byte, N data bytes, deselect.
//            Received bytes leave on a valid/ready port with backpressure.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   CLK1, RESET_N                  clock, synchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_addr[23:0], req_len[15:0]  flash address, byte count (0 = no SPI)
//   req_dual                       1 = dual-output read
//   abort                          terminate current transaction
//   busy, done                     status, one-cycle completion pulse
//   rd_valid/rd_ready/rd_data[7:0] received byte stream
//   eng_start/eng_write/eng_dual/eng_tx[7:0]  byte engine command
//   eng_done/eng_rx[7:0]           byte engine completion and read data
//   spi_ss_n                       flash chip select, active low
//============================================================================
module spi_flash_sequencer #(
  parameter int         CS_SETUP  = 2,
  parameter int         CS_HIGH   = 4,
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_DREAD = 8'h3B
) (
  input  logic        CLK1,
  input  logic        RESET_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_len,
  input  logic        req_dual,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [7:0]  rd_data,
  output logic        eng_start,
  output logic        eng_write,
  output logic        eng_dual,
  output logic [7:0]  eng_tx,
  input  logic        eng_done,
  input  logic [7:0]  eng_rx,
  output logic        spi_ss_n
);

  localparam int WAIT_W = 8;
  localparam logic [WAIT_W-1:0] c_setup_load = WAIT_W'(CS_SETUP - 1);
  localparam logic [WAIT_W-1:0] c_high_load  = WAIT_W'(CS_HIGH - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SETUP = 4'd1,
    S_CMD   = 4'd2,
    S_ADR2  = 4'd3,
    S_ADR1  = 4'd4,
    S_ADR0  = 4'd5,
    S_DUMMY = 4'd6,
    S_DATA  = 4'd7,
    S_HOLD  = 4'd8,
    S_DESEL = 4'd9
  } state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [23:0]       r_addr;
  logic [15:0]       r_rem;
  logic              r_dual;
  logic              r_abort_pend;
  logic              r_done;
  logic              r_rd_valid;
  logic [7:0]        r_rd_data;
  logic              r_eng_start;
  logic              r_eng_write;
  logic              r_eng_dual;
  logic [7:0]        r_eng_tx;
  logic              r_ss_n;

  logic              w_eng_wait;
  logic              w_abort_any;
  logic              w_to_desel;
  state_t            w_adv_state;
  logic [7:0]        w_adv_tx;

  // States in which an engine byte is outstanding.
  assign w_eng_wait  = (r_state == S_CMD)  || (r_state == S_ADR2)  ||
                       (r_state == S_ADR1) || (r_state == S_ADR0)  ||
                       (r_state == S_DUMMY) || (r_state == S_DATA);
  // An abort seen while a byte is in flight is remembered until that byte ends.
  assign w_abort_any = abort || r_abort_pend;

  // All the ways into DESEL share one set of register updates.
  assign w_to_desel  = ((r_state == S_SETUP) && abort) ||
                       (w_eng_wait && eng_done && w_abort_any) ||
                       ((r_state == S_HOLD) &&
                        (abort || (r_rd_valid && rd_ready && (r_rem == 16'd0))));

  // Next header state and its byte, used when the current header byte ends.
  always_comb begin
    w_adv_state = S_DATA;
    w_adv_tx    = 8'h00;
    case (r_state)
      S_CMD:   begin w_adv_state = S_ADR2; w_adv_tx = r_addr[23:16]; end
      S_ADR2:  begin w_adv_state = S_ADR1; w_adv_tx = r_addr[15:8];  end
      S_ADR1:  begin w_adv_state = S_ADR0; w_adv_tx = r_addr[7:0];   end
      S_ADR0:  begin w_adv_state = r_dual ? S_DUMMY : S_DATA;        end
      default: begin w_adv_state = S_DATA;                          end
    endcase
  end

  always_ff @(posedge CLK1) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_addr       <= '0;
      r_rem        <= '0;
      r_dual       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_done       <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= 8'h00;
      r_eng_start  <= 1'b0;
      r_eng_write  <= 1'b0;
      r_eng_dual   <= 1'b0;
      r_eng_tx     <= 8'h00;
      r_ss_n       <= 1'b1;
    end else begin
      r_done      <= 1'b0;
      r_eng_start <= 1'b0;
      if (w_to_desel) begin
        r_state      <= S_DESEL;
        r_ss_n       <= 1'b1;
        r_done       <= 1'b1;
        r_wait       <= c_high_load;
        r_rd_valid   <= 1'b0;
        r_eng_write  <= 1'b0;
        r_eng_dual   <= 1'b0;
        r_eng_tx     <= 8'h00;
        r_abort_pend <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_abort_pend <= 1'b0;
            if (req_valid) begin
              r_addr <= req_addr;
              r_rem  <= req_len;
              r_dual <= req_dual;
              if (req_len == 16'd0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_SETUP;
                r_ss_n  <= 1'b0;
                r_wait  <= c_setup_load;
              end
            end
          end
          S_SETUP: begin
            if (r_wait == '0) begin
              r_state     <= S_CMD;
              r_eng_start <= 1'b1;
              r_eng_write <= 1'b1;
              r_eng_dual  <= 1'b0;
              r_eng_tx    <= r_dual ? CMD_DREAD : CMD_READ;
            end else begin
              r_wait <= r_wait - 1'b1;
            end
          end
          S_CMD, S_ADR2, S_ADR1, S_ADR0, S_DUMMY: begin
            if (abort) r_abort_pend <= 1'b1;
            if (eng_done) begin
              r_state     <= w_adv_state;
              r_eng_start <= 1'b1;
              r_eng_tx    <= w_adv_tx;
              if (w_adv_state == S_DATA) begin
                r_eng_write <= 1'b0;
                r_eng_dual  <= r_dual;
              end
            end
          end
          S_DATA: begin
            if (abort) r_abort_pend <= 1'b1;
            if (eng_done) begin
              r_rd_data  <= eng_rx;
              r_rd_valid <= 1'b1;
              r_rem      <= r_rem - 16'd1;
              r_state    <= S_HOLD;
            end
          end
          S_HOLD: begin
            // The last-byte handshake is routed to DESEL above, so here
            // more bytes always remain.
            if (r_rd_valid && rd_ready) begin
              r_rd_valid  <= 1'b0;
              r_state     <= S_DATA;
              r_eng_start <= 1'b1;
            end
          end
          S_DESEL: begin
            if (r_wait == '0) begin
              r_state <= S_IDLE;
            end else begin
              r_wait <= r_wait - 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign eng_start = r_eng_start;
  assign eng_write = r_eng_write;
  assign eng_dual  = r_eng_dual;
  assign eng_tx    = r_eng_tx;
  assign spi_ss_n  = r_ss_n;

endmodule
`default_nettype wire
